// File: rtl/distance_fnd_scanner_pkg.sv
// Shared constants for the distance FND scanner: segment codes, digit selects, converter states.
// Latency: n/a (package only).
// Backpressure: n/a.
package distance_fnd_scanner_pkg;

    // Converter sequencing: load in IDLE, one adjust+shift per SHIFT cycle, commit in DONE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int unsigned BIN_W        = 12;
    localparam int unsigned BCD_W        = 16;
    localparam int unsigned SHIFT_CYCLES = 12;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low digit selects, digit 0 is the rightmost (units) digit.
    localparam logic [3:0] DIG_SEL_0 = 4'b1110;
    localparam logic [3:0] DIG_SEL_1 = 4'b1101;
    localparam logic [3:0] DIG_SEL_2 = 4'b1011;
    localparam logic [3:0] DIG_SEL_3 = 4'b0111;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] dig_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    return DIG_SEL_0;
            2'd1:    return DIG_SEL_1;
            2'd2:    return DIG_SEL_2;
            default: return DIG_SEL_3;
        endcase
    endfunction

endpackage

// File: rtl/distance_fnd_scanner_bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
// Latency: start edge -> 12 SHIFT cycles -> 1 DONE cycle (done=1, bcd valid during DONE).
// Backpressure: none; start is honoured only in IDLE or DONE, caller holds off otherwise (busy=1).
// Ports: clk, reset (async, active-high), start/bin (load request), busy (SHIFT or DONE),
//        done (DONE cycle strobe), bcd (four packed BCD digits, digit 3 in [15:12]).
module bin2bcd_seq
    import distance_fnd_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SR_W = BCD_W + BIN_W;

    conv_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SR_W-1:0]  adj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
        adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin};
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = {adj[SR_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SHIFT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back conversion: skip IDLE when the next value is already waiting.
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin};
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign bcd  = sr_q[SR_W-1:BIN_W];

endmodule

// File: rtl/distance_fnd_scanner.sv
// Distance display: converts sampled cm readings to BCD and multiplexes a 4-digit active-low FND.
// Latency: strobe edge to display registers in 14 edges (inclusive); over-range shows next edge.
// Backpressure: none; strobes while converting park in a one-entry latest-wins pending slot.
// Ports: clk, reset (async, active-high), dist_in/dist_valid (reading + strobe),
//        fnd_digit (active-low digit select), fnd_data (active-low segments), busy (converting).
module distance_fnd_scanner
    import distance_fnd_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned RANGE_MAX = 400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] dist_in,
    input  logic             dist_valid,
    output logic [3:0]       fnd_digit,
    output logic [7:0]       fnd_data,
    output logic             busy
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             strobe_ok, strobe_ovr;
    logic             conv_start, conv_busy, conv_done;
    logic [BIN_W-1:0] conv_bin;
    logic [BCD_W-1:0] conv_bcd;

    logic             pend_vld_q, pend_vld_d;
    logic [BIN_W-1:0] pend_q, pend_d;
    logic [BCD_W-1:0] disp_q, disp_d;
    logic             over_q, over_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       dig_idx_q, dig_idx_d;
    logic [3:0]       fnd_digit_q;
    logic [7:0]       fnd_data_q, seg_d;
    logic [3:0]       nib;
    logic             blank;

    assign strobe_ok  = dist_valid && (32'(dist_in) <= RANGE_MAX);
    assign strobe_ovr = dist_valid && (32'(dist_in) >  RANGE_MAX);

    // A fresh strobe in the DONE cycle is newer than anything pending, so it is loaded directly.
    // An over-range strobe supersedes whatever was pending.
    assign conv_start = (strobe_ok && (!conv_busy || conv_done))
                     || (conv_done && pend_vld_q && !strobe_ovr);
    assign conv_bin   = strobe_ok ? dist_in : pend_q;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        over_d     = over_q;

        if (strobe_ok && conv_busy && !conv_done) begin
            pend_vld_d = 1'b1;
            pend_d     = dist_in;
        end
        if (conv_done || strobe_ovr) begin
            pend_vld_d = 1'b0;
        end

        if (conv_done) begin
            disp_d = conv_bcd;
            over_d = 1'b0;
        end
        if (strobe_ovr) begin
            over_d = 1'b1;
        end
    end

    // Digit scan: the slot timer never depends on the converter, so the display never stalls.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 2'd1;
        end
    end

    // Segment lookup for the current slot, with leading-zero blanking (digit 0 always shown).
    always_comb begin
        nib   = disp_q[{dig_idx_q, 2'b00} +: 4];
        blank = 1'b0;
        case (dig_idx_q)
            2'd3:    blank = (disp_q[15:12] == 4'd0);
            2'd2:    blank = (disp_q[15:8]  == 8'd0);
            2'd1:    blank = (disp_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        if (over_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_of(nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            disp_q      <= '0;
            over_q      <= 1'b0;
            scan_cnt_q  <= '0;
            dig_idx_q   <= '0;
            fnd_digit_q <= DIG_SEL_0;
            fnd_data_q  <= SEG_0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            over_q      <= over_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            // Select and segments come from the same slot index in the same edge.
            fnd_digit_q <= dig_sel(dig_idx_q);
            fnd_data_q  <= seg_d;
        end
    end

    assign fnd_digit = fnd_digit_q;
    assign fnd_data  = fnd_data_q;
    assign busy      = conv_busy;

endmodule

// File: tb/tb_distance_fnd_scanner.sv
module tb_distance_fnd_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] dist_in, dist_in_m;
    logic        dist_valid, dist_valid_m;
    logic [3:0]  fnd_digit, fnd_digit_m;
    logic [7:0]  fnd_data, fnd_data_m;
    logic        busy, busy_m;

    int n_checks = 0;
    int n_fail   = 0;
    int k_edges  = 0;

    always #5 clk = ~clk;

    distance_fnd_scanner #(.SCAN_DIV(4), .RANGE_MAX(400)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .fnd_digit  (fnd_digit),
        .fnd_data   (fnd_data),
        .busy       (busy)
    );

    distance_fnd_scanner #(.SCAN_DIV(4), .RANGE_MAX(4095)) u_dut_max (
        .clk        (clk),
        .reset      (reset),
        .dist_in    (dist_in_m),
        .dist_valid (dist_valid_m),
        .fnd_digit  (fnd_digit_m),
        .fnd_data   (fnd_data_m),
        .busy       (busy_m)
    );

    // Active edges since reset release; drives the expected scan position.
    always @(posedge clk) begin
        if (reset) k_edges <= 0;
        else       k_edges <= k_edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slot visible after edge k: index register advances every 4 edges, output lags one edge.
    function automatic int model_idx();
        return (k_edges == 0) ? 0 : ((k_edges - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] model_sel(input int idx);
        case (idx)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] v, input bit on_max);
        if (on_max) begin dist_in_m = v; dist_valid_m = 1'b1; end
        else        begin dist_in   = v; dist_valid   = 1'b1; end
        tick();
        dist_valid   = 1'b0;
        dist_valid_m = 1'b0;
    endtask

    task automatic expect_digits(input string tag, input bit on_max,
                                 input logic [7:0] e3, input logic [7:0] e2,
                                 input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] cap [4];
        bit         seen [4];
        int         idx;
        for (int i = 0; i < 4; i++) begin cap[i] = 8'h00; seen[i] = 1'b0; end
        for (int i = 0; i < 20; i++) begin
            tick();
            idx       = model_idx();
            cap[idx]  = on_max ? fnd_data_m : fnd_data;
            seen[idx] = 1'b1;
        end
        check({tag, "_cover"}, 32'(seen[0] & seen[1] & seen[2] & seen[3]), 32'd1);
        check({tag, "_d3"}, 32'(cap[3]), 32'(e3));
        check({tag, "_d2"}, 32'(cap[2]), 32'(e2));
        check({tag, "_d1"}, 32'(cap[1]), 32'(e1));
        check({tag, "_d0"}, 32'(cap[0]), 32'(e0));
    endtask

    initial begin
        bit         busy_dropped;
        bit         busy_seen;
        bit         saw_wrap;
        logic [3:0] prev;

        reset = 1'b1;
        dist_in = '0; dist_valid = 1'b0;
        dist_in_m = '0; dist_valid_m = 1'b0;
        repeat (3) tick();
        check("rst_digit", 32'(fnd_digit), 32'h0E);
        check("rst_data",  32'(fnd_data),  32'hC0);
        check("rst_busy",  32'(busy),      32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // 123: busy through 13 edges, low after the 14th, then "123" with digit 3 blank.
        strobe(12'd123, 1'b0);
        check("t123_busy_e0", 32'(busy), 32'd1);
        repeat (12) tick();
        check("t123_busy_e12", 32'(busy), 32'd1);
        tick();
        check("t123_busy_e13", 32'(busy), 32'd0);
        expect_digits("t123", 1'b0, 8'hFF, 8'hF9, 8'hA4, 8'hB0);

        // 7, then 250 at edge 5 and 305 at edge 8: 7 shown, 250 dropped, 305 shown.
        strobe(12'd7, 1'b0);
        busy_dropped = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            if (e == 5)      begin dist_in = 12'd250; dist_valid = 1'b1; end
            else if (e == 8) begin dist_in = 12'd305; dist_valid = 1'b1; end
            else             dist_valid = 1'b0;
            tick();
            if (e < 26 && !busy) busy_dropped = 1'b1;
            if (e == 26) check("t7_busy_end", 32'(busy), 32'd0);
            if (e >= 14) check("t7_data", 32'(fnd_data),
                               (model_idx() == 0) ? 32'hF8 : 32'hFF);
        end
        dist_valid = 1'b0;
        check("t7_busy_cont", 32'(busy_dropped), 32'd0);
        expect_digits("t305", 1'b0, 8'hFF, 8'hB0, 8'hC0, 8'h92);

        // Over-range shows dashes; a following 0 clears it and shows a lone "0".
        strobe(12'd401, 1'b0);
        check("t401_busy", 32'(busy), 32'd0);
        expect_digits("t401", 1'b0, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        strobe(12'd0, 1'b0);
        repeat (13) tick();
        check("t0_busy", 32'(busy), 32'd0);
        expect_digits("t0", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        // Full-scale value on the wide-range instance: no blanking at all.
        strobe(12'd4095, 1'b1);
        repeat (13) tick();
        check("t4095_busy", 32'(busy_m), 32'd0);
        expect_digits("t4095", 1'b1, 8'h99, 8'hC0, 8'h90, 8'h92);

        // Reset six edges into a conversion of 88: immediate reset outputs, nothing committed.
        strobe(12'd88, 1'b0);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("trst_digit", 32'(fnd_digit), 32'h0E);
        check("trst_data",  32'(fnd_data),  32'hC0);
        check("trst_busy",  32'(busy),      32'd0);
        repeat (2) tick();
        reset = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        check("trst_no_busy", 32'(busy_seen), 32'd0);
        expect_digits("trst", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        // Free run: rotation every 4 edges, one select low, 0111 wraps to 1110.
        saw_wrap = 1'b0;
        prev     = fnd_digit;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("scan_sel", 32'(fnd_digit), 32'(model_sel(model_idx())));
            check("scan_onehot", $countones(~fnd_digit), 32'd1);
            if (prev == 4'b0111 && fnd_digit == 4'b1110) saw_wrap = 1'b1;
            prev = fnd_digit;
        end
        check("scan_wrap", 32'(saw_wrap), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
